div_unit: RTL and testbench

- Iterative 32-bit integer divider for the 54-instruction MIPS core, serving DIV/DIVU.
- Sits directly downstream of the register file: dividend comes from the Rs read port, divisor from the Rt read port.
- Quotient and remainder go to the LO/HI registers.
- Restoring algorithm, one quotient bit per cycle, start/busy/done handshake; the controller stalls the PC while busy.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_sign_fix.sv | 14 +
 rtl/div_unit.sv | 162 ++++++++++++++++
 tb/tb_div_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative MIPS DIV/DIVU unit.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's complement negate; gives WIDTH-bit unsigned abs or a signed result fix-up.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] value_in,
    input  logic             negate,
    output logic [WIDTH-1:0] value_out
);

    assign value_out = negate ? -value_in : value_in;

endmodule

// File: rtl/div_unit.sv
// Restoring divider, one quotient bit per cycle, for MIPS DIV/DIVU (q to LO, r to HI).
// Define DIV_ZERO_EARLY_EN to finish divide-by-zero one cycle after start.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic [WIDTH-1:0] abs_dividend, abs_divisor;
    logic [WIDTH-1:0] fixed_quo, fixed_rem;
    logic [WIDTH-1:0] q_res, r_res;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic             load;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_dividend (
        .value_in  (dividend),
        .negate    (is_signed & dividend[WIDTH-1]),
        .value_out (abs_dividend)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_divisor (
        .value_in  (divisor),
        .negate    (is_signed & divisor[WIDTH-1]),
        .value_out (abs_divisor)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value_in  (quo_q),
        .negate    (neg_quo_q),
        .value_out (fixed_quo)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value_in  (rem_q),
        .negate    (neg_rem_q),
        .value_out (fixed_rem)
    );

    // The partial remainder stays below the divisor, so after the subtract it fits WIDTH bits.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvs_q});

    assign q_res = zero_q ? '1 : fixed_quo;
    assign r_res = zero_q ? dvd_q : fixed_rem;

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign q    = done ? q_res : q_q;
    assign r    = done ? r_res : r_q;

    assign load = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        q_d       = q_q;
        r_d       = r_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                rem_d = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], fits};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                q_d     = q_res;
                r_d     = r_res;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request is accepted from IDLE or back-to-back from DONE.
        if (load) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = abs_dividend;
            dvs_d     = abs_divisor;
            dvd_d     = dividend;
            neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = is_signed & dividend[WIDTH-1];
            zero_d    = (divisor == '0);
`ifdef DIV_ZERO_EARLY_EN
            state_d   = (divisor == '0) ? DONE : RUN;
`else
            state_d   = RUN;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            q_q       <= q_d;
            r_q       <= r_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
// Honours DIV_ZERO_EARLY_EN for the expected divide-by-zero latency.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;

    int          numChecks = 0;
    int          numErrors = 0;
    logic [31:0] expQ;
    logic [31:0] expR;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: SV integer division truncates toward zero and % takes the dividend's sign.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, qq, rr;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            x = {{32{a[31]}}, a};
            y = {{32{b[31]}}, b};
        end else begin
            x = {32'd0, a};
            y = {32'd0, b};
        end
        qq = x / y;
        rr = x % y;
        return {qq[31:0], rr[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a division in the current cycle and returns in the done cycle.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input int gapAt, input int gapLen);
        int          k;
        int          busyCnt;
        int          expLat;
        int          expBusy;
        logic        seen;
        logic [63:0] m;
        m       = model(s, a, b);
        expQ    = m[63:32];
        expR    = m[31:0];
        expLat  = 33 + gapLen;
        expBusy = 32;
`ifdef DIV_ZERO_EARLY_EN
        if (b == 32'd0) begin
            expLat  = 1;
            expBusy = 0;
        end
`endif
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        k         = 0;
        busyCnt   = 0;
        seen      = 1'b0;
        while (!seen && k < 200) begin
            tick();
            k++;
            if (k == 1) begin
                start     = 1'b0;
                is_signed = ~s;
                dividend  = $urandom;
                divisor   = $urandom;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busyCnt++;
                if (k == gapAt) begin
                    ena = 1'b0;
                    repeat (gapLen) begin
                        tick();
                        k++;
                        checkOutput("gapBusy", {31'd0, busy}, 32'd1);
                    end
                    ena = 1'b1;
                end
            end
        end
        checkOutput("doneSeen", {31'd0, seen}, 32'd1);
        checkOutput("latency", k, expLat);
        checkOutput("busyCycles", busyCnt, expBusy);
        checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
        checkOutput("q", q, expQ);
        checkOutput("r", r, expR);
    endtask

    // Optionally stretches done with ena=0, then checks the pulse ends and the result holds.
    task automatic finishOp(input int hold);
        ena = 1'b0;
        repeat (hold) begin
            tick();
            checkOutput("doneStretch", {31'd0, done}, 32'd1);
        end
        ena = 1'b1;
        tick();
        checkOutput("donePulse", {31'd0, done}, 32'd0);
        checkOutput("idleBusy", {31'd0, busy}, 32'd0);
        checkOutput("qHold", q, expQ);
        checkOutput("rHold", r, expR);
    endtask

    initial begin
        int          cnt;
        int          k;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] m;

        rst       = 1'b1;
        ena       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("rstQ", q, 32'd0);
        checkOutput("rstR", r, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);

        applyStimulus(1'b0, 32'd100, 32'd7, 0, 0);                 finishOp(0);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);           finishOp(0);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);           finishOp(0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);   finishOp(0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);           finishOp(0);
        applyStimulus(1'b0, 32'd5, 32'd0, 0, 0);                   finishOp(0);
        applyStimulus(1'b1, 32'd5, 32'd0, 0, 0);                   finishOp(0);
        applyStimulus(1'b1, 32'h8000_0000, 32'd0, 0, 0);           finishOp(0);

        applyStimulus(1'b0, 32'd12345678, 32'd1000, 10, 5);        finishOp(2);

        applyStimulus(1'b0, 32'd100, 32'd7, 0, 0);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);           finishOp(0);

        // A start raised while busy must not disturb the division in flight.
        m         = model(1'b0, 32'd1000, 32'd7);
        expQ      = m[63:32];
        expR      = m[31:0];
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'hFFFF_FFFD;
        tick();
        start = 1'b0;
        k     = 0;
        while (!done && k < 60) begin
            tick();
            k++;
        end
        checkOutput("ignDone", {31'd0, done}, 32'd1);
        checkOutput("ignQ", q, expQ);
        checkOutput("ignR", r, expR);
        finishOp(0);

        // Reset mid-operation aborts without a done pulse.
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortQ", q, 32'd0);
        checkOutput("abortR", r, 32'd0);
        cnt = 0;
        repeat (40) begin
            tick();
            if (done) cnt++;
        end
        checkOutput("abortNoDone", cnt, 32'd0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            applyStimulus(s, a, b, 0, 0);
            if ($urandom_range(0, 2) != 0) finishOp($urandom_range(0, 2));
        end
        finishOp(0);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
